mc_control_fsm: RTL

//  Main control state machine of the multi-cycle MIPS cpu. Sits between the instruction register and the datapath.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mc_alu_decoder.sv | 37 +++
 rtl/mc_control_fsm.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, mux selects,
// ALU controls and FSM state codes.
package mips_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    // aluop: how the decoder chooses alucontrol
    localparam logic [1:0] AluopAdd   = 2'b00;
    localparam logic [1:0] AluopSub   = 2'b01;
    localparam logic [1:0] AluopFunct = 2'b10;
    localparam logic [1:0] AluopNone  = 2'b11;

    localparam logic [1:0] SrcbB     = 2'b00;
    localparam logic [1:0] SrcbFour  = 2'b01;
    localparam logic [1:0] SrcbImm   = 2'b10;
    localparam logic [1:0] SrcbImmSh = 2'b11;

    localparam logic [1:0] PcsrcAlu    = 2'b00;
    localparam logic [1:0] PcsrcAluOut = 2'b01;
    localparam logic [1:0] PcsrcJump   = 2'b10;

    localparam logic [3:0] StFetch  = 4'd0;
    localparam logic [3:0] StDecode = 4'd1;
    localparam logic [3:0] StMemadr = 4'd2;
    localparam logic [3:0] StMemrd  = 4'd3;
    localparam logic [3:0] StMemwb  = 4'd4;
    localparam logic [3:0] StMemwr  = 4'd5;
    localparam logic [3:0] StExec   = 4'd6;
    localparam logic [3:0] StAluwb  = 4'd7;
    localparam logic [3:0] StBranch = 4'd8;
    localparam logic [3:0] StAddiex = 4'd9;
    localparam logic [3:0] StAddiwb = 4'd10;
    localparam logic [3:0] StJump   = 4'd11;
    localparam logic [3:0] StHalt   = 4'd12;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU control decode: aluop + funct -> alucontrol, plus a flag for unsupported R-type functs.
module mc_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       illegal_funct
);

    logic [2:0] funct_ctl;

    // funct legality is reported regardless of aluop so DECODE can flag it early
    always_comb begin
        funct_ctl     = AluAnd;
        illegal_funct = 1'b0;
        case (funct)
            FnAdd:   funct_ctl = AluAdd;
            FnSub:   funct_ctl = AluSub;
            FnAnd:   funct_ctl = AluAnd;
            FnOr:    funct_ctl = AluOr;
            FnSlt:   funct_ctl = AluSlt;
            default: illegal_funct = 1'b1;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            AluopAdd:   alucontrol = AluAdd;
            AluopSub:   alucontrol = AluSub;
            AluopFunct: alucontrol = funct_ctl;
            default:    alucontrol = 3'b000;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM: Moore output decode, state sequencing and a
// retired-instruction counter.
module mc_control_fsm
    import mips_pkg::*;
#(
    parameter bit ENABLE_JUMP  = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pcwrite,
    output logic        pcwrite_en,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal,
    output logic        halted,
    output logic [31:0] instret
);

    logic [3:0]  state_q, state_d;
    logic [31:0] instret_q;
    logic        op_legal;
    logic        illegal_funct;
    logic        retire;
    logic [1:0]  aluop;
    logic        pcwrite_raw, memwrite_raw, irwrite_raw, regwrite_raw, branch;

    mc_alu_decoder u_alu_decoder (
        .aluop         (aluop),
        .funct         (funct),
        .alucontrol    (alucontrol),
        .illegal_funct (illegal_funct)
    );

    always_comb begin
        case (opcode)
            OpRtype, OpLw, OpSw, OpBeq, OpAddi: op_legal = 1'b1;
            OpJ:                                op_legal = ENABLE_JUMP;
            default:                            op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (!op_legal) begin
                    retire  = ~ILLEGAL_TRAP;
                    state_d = ILLEGAL_TRAP ? StHalt : StFetch;
                end else begin
                    case (opcode)
                        OpLw, OpSw: state_d = StMemadr;
                        OpRtype:    state_d = StExec;
                        OpBeq:      state_d = StBranch;
                        OpAddi:     state_d = StAddiex;
                        OpJ:        state_d = StJump;
                        default:    state_d = StFetch;
                    endcase
                end
            end
            StMemadr: state_d = (opcode == OpLw) ? StMemrd : StMemwr;
            StMemrd:  state_d = StMemwb;
            StExec:   state_d = StAluwb;
            StAddiex: state_d = StAddiwb;
            StMemwb, StMemwr, StAluwb, StBranch, StAddiwb, StJump: begin
                retire  = 1'b1;
                state_d = StFetch;
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    always_comb begin
        pcwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        branch       = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SrcbB;
        pcsrc        = PcsrcAlu;
        aluop        = AluopNone;
        case (state_q)
            StFetch: begin
                irwrite_raw = 1'b1;
                pcwrite_raw = 1'b1;
                alusrcb     = SrcbFour;
                aluop       = AluopAdd;
            end
            StDecode: begin
                alusrcb = SrcbImmSh;
                aluop   = AluopAdd;
            end
            StMemadr, StAddiex: begin
                alusrca = 1'b1;
                alusrcb = SrcbImm;
                aluop   = AluopAdd;
            end
            StMemrd: iord = 1'b1;
            StMemwb: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            StMemwr: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            StExec: begin
                alusrca = 1'b1;
                aluop   = AluopFunct;
            end
            StAluwb: begin
                regdst       = 1'b1;
                regwrite_raw = ~illegal_funct;
            end
            StBranch: begin
                alusrca = 1'b1;
                aluop   = AluopSub;
                pcsrc   = PcsrcAluOut;
                branch  = 1'b1;
            end
            StAddiwb: regwrite_raw = 1'b1;
            StJump: begin
                pcsrc       = PcsrcJump;
                pcwrite_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by reset itself so nothing writes while reset is held in FETCH
    assign pcwrite    = pcwrite_raw & ~reset;
    assign pcwrite_en = (pcwrite_raw | (branch & zero)) & ~reset;
    assign memwrite   = memwrite_raw & ~reset;
    assign irwrite    = irwrite_raw & ~reset;
    assign regwrite   = regwrite_raw & ~reset;

    assign illegal = (state_q == StDecode) &&
                     (!op_legal || (opcode == OpRtype && illegal_funct));
    assign halted  = (state_q == StHalt);
    assign instret = instret_q;

endmodule
